// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multicycle RV control unit: states, opcodes, ALU codes.
// Optional MC_CTRL_BRANCH_EXT_EN widens the set of legal branch funct3 values.
package rv_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_ALUWB    = 4'd7,
      S_EXECI    = 4'd8,
      S_JAL      = 4'd9,
      S_BRANCH   = 4'd10,
      S_TRAP     = 4'd11
   } state_t;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_BR  = 7'b1100011;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   // Wide enough for MEM_LAT-1 with MEM_LAT up to 4
   localparam int unsigned CNT_W = 2;

   function automatic logic branch_legal(input logic [2:0] funct3);
`ifdef MC_CTRL_BRANCH_EXT_EN
      return (funct3 == 3'b000) || (funct3 == 3'b001) ||
             (funct3 == 3'b100) || (funct3 == 3'b101);
`else
      return (funct3 == 3'b000);
`endif
   endfunction

   // Illegal funct3 never reaches BRANCH, so one take rule serves both builds
   function automatic logic branch_take(input logic [2:0] funct3, input logic zero,
                                        input logic sign_flag);
      case (funct3)
         3'b000:  return zero;
         3'b001:  return !zero;
         3'b100:  return sign_flag;
         3'b101:  return !sign_flag;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps funct3/funct7b5 to an alu_control code and flags funct3 values with no ALU op.
module alu_decoder
   import rv_ctrl_pkg::*;
(
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       is_rtype,
   output logic [2:0] alu_control_c,
   output logic       legal_c
);

   always_comb begin
      alu_control_c = ALU_ADD;
      legal_c       = 1'b1;
      case (funct3)
         3'b000:  alu_control_c = (is_rtype && funct7b5) ? ALU_SUB : ALU_ADD;
         3'b010:  alu_control_c = ALU_SLT;
         3'b110:  alu_control_c = ALU_OR;
         3'b111:  alu_control_c = ALU_AND;
         default: legal_c = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32 subset control FSM with variable-latency loads and a sticky trap.
// Define MC_CTRL_BRANCH_EXT_EN to accept bne/blt/bge in addition to beq.
module multicycle_ctrl
   import rv_ctrl_pkg::*;
#(
   parameter int unsigned MEM_LAT = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   input  logic       sign_flag,
   output logic       pc_write,
   output logic       ir_write,
   output logic       mem_write,
   output logic       reg_write,
   output logic       adr_src,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] result_src,
   output logic [1:0] imm_src,
   output logic [2:0] alu_control,
   output logic [3:0] state_dbg,
   output logic       illegal
);

   state_t           state;
   state_t           decode_next;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       dec_alu;
   logic             dec_legal;

   alu_decoder u_alu_decoder (
      .funct3        (funct3),
      .funct7b5      (funct7b5),
      .is_rtype      (opcode == OP_R),
      .alu_control_c (dec_alu),
      .legal_c       (dec_legal)
   );

   // DECODE dispatch, including legality of funct3 for R/I/branch
   always_comb begin
      decode_next = S_TRAP;
      case (opcode)
         OP_LW, OP_SW: decode_next = S_MEMADR;
         OP_R:         if (dec_legal) decode_next = S_EXECR;
         OP_I:         if (dec_legal) decode_next = S_EXECI;
         OP_JAL:       decode_next = S_JAL;
         OP_BR:        if (branch_legal(funct3)) decode_next = S_BRANCH;
         default:      decode_next = S_TRAP;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= S_FETCH;
         cnt     <= '0;
         illegal <= 1'b0;
      end else begin
         case (state)
            S_FETCH:  state <= S_DECODE;
            S_DECODE: begin
               state   <= decode_next;
               illegal <= (decode_next == S_TRAP);
            end
            S_MEMADR: begin
               state <= (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
               cnt   <= '0;
            end
            S_MEMREAD: begin
               if (cnt == CNT_W'(MEM_LAT - 1)) begin
                  state <= S_MEMWB;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            S_EXECR, S_EXECI, S_JAL:                 state <= S_ALUWB;
            S_MEMWB, S_MEMWRITE, S_ALUWB, S_BRANCH:  state <= S_FETCH;
            default: begin
               state   <= S_TRAP;
               illegal <= 1'b1;
            end
         endcase
      end
   end

   assign state_dbg = 4'(state);

   always_comb begin
      case (opcode)
         OP_SW:   imm_src = 2'b01;
         OP_BR:   imm_src = 2'b10;
         OP_JAL:  imm_src = 2'b11;
         default: imm_src = 2'b00;
      endcase
   end

   // Moore decode of datapath controls; branch pc_write is the only Mealy term
   always_comb begin
      pc_write    = 1'b0;
      ir_write    = 1'b0;
      mem_write   = 1'b0;
      reg_write   = 1'b0;
      adr_src     = 1'b0;
      alu_src_a   = 2'b00;
      alu_src_b   = 2'b00;
      result_src  = 2'b00;
      alu_control = ALU_ADD;
      case (state)
         S_FETCH: begin
            ir_write   = 1'b1;
            pc_write   = 1'b1;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
         end
         S_DECODE: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
         end
         S_MEMADR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
         end
         S_MEMREAD: adr_src = 1'b1;
         S_MEMWB: begin
            result_src = 2'b01;
            reg_write  = 1'b1;
         end
         S_MEMWRITE: begin
            adr_src   = 1'b1;
            mem_write = 1'b1;
         end
         S_EXECR: begin
            alu_src_a   = 2'b10;
            alu_control = dec_alu;
         end
         S_EXECI: begin
            alu_src_a   = 2'b10;
            alu_src_b   = 2'b01;
            alu_control = dec_alu;
         end
         S_ALUWB: reg_write = 1'b1;
         S_JAL: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b10;
            pc_write  = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a   = 2'b10;
            alu_control = ALU_SUB;
            pc_write    = branch_take(funct3, zero, sign_flag);
         end
         default: ;
      endcase
      if (!rst) begin
         pc_write  = 1'b0;
         ir_write  = 1'b0;
         reg_write = 1'b0;
         mem_write = 1'b0;
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl (MEM_LAT=3): directed scenarios plus
// random instructions checked against a per-instruction trace model.
module tb_multicycle_ctrl;

   localparam int unsigned LAT = 3;
   typedef int trace_t[$];

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [6:0] opcode = 7'd0;
   logic [2:0] funct3 = 3'd0;
   logic       funct7b5 = 1'b0;
   logic       zero = 1'b0;
   logic       sign_flag = 1'b0;
   logic       pc_write, ir_write, mem_write, reg_write, adr_src, illegal;
   logic [1:0] alu_src_a, alu_src_b, result_src, imm_src;
   logic [2:0] alu_control;
   logic [3:0] state_dbg;
   logic [16:0] obs;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   multicycle_ctrl #(.MEM_LAT(LAT)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
      .zero(zero), .sign_flag(sign_flag), .pc_write(pc_write), .ir_write(ir_write),
      .mem_write(mem_write), .reg_write(reg_write), .adr_src(adr_src),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
      .imm_src(imm_src), .alu_control(alu_control), .state_dbg(state_dbg),
      .illegal(illegal)
   );

   assign obs = {pc_write, ir_write, mem_write, reg_write, adr_src, alu_src_a, alu_src_b,
                 result_src, imm_src, alu_control, illegal};

   function automatic bit alu_ok(logic [2:0] f3);
      return (f3 == 3'd0) || (f3 == 3'd2) || (f3 == 3'd6) || (f3 == 3'd7);
   endfunction

   function automatic bit br_ok(logic [2:0] f3);
`ifdef MC_CTRL_BRANCH_EXT_EN
      return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd4) || (f3 == 3'd5);
`else
      return (f3 == 3'd0);
`endif
   endfunction

   // Expected sequence of states visited by one instruction, starting at FETCH
   function automatic trace_t trace(logic [6:0] op, logic [2:0] f3);
      trace_t t;
      t = {0, 1};
      if (op == 7'b0000011) begin
         t.push_back(2);
         for (int i = 0; i < int'(LAT); i++) t.push_back(3);
         t.push_back(4);
      end else if (op == 7'b0100011) begin t.push_back(2); t.push_back(5); end
      else if (op == 7'b0110011 && alu_ok(f3)) begin t.push_back(6); t.push_back(7); end
      else if (op == 7'b0010011 && alu_ok(f3)) begin t.push_back(8); t.push_back(7); end
      else if (op == 7'b1101111) begin t.push_back(9); t.push_back(7); end
      else if (op == 7'b1100011 && br_ok(f3)) t.push_back(10);
      else t.push_back(11);
      return t;
   endfunction

   function automatic logic [2:0] exp_alu(logic [2:0] f3, logic sub);
      case (f3)
         3'd0:    return sub ? 3'b001 : 3'b000;
         3'd2:    return 3'b101;
         3'd6:    return 3'b011;
         3'd7:    return 3'b010;
         default: return 3'b000;
      endcase
   endfunction

   // Expected output vector for a given state and inputs, with rst high
   function automatic logic [16:0] exp_out(int st, logic [6:0] op, logic [2:0] f3, logic f7,
                                           logic z, logic s);
      logic pcw, irw, mw, rw, adr, ill;
      logic [1:0] sa, sb, rs, imm;
      logic [2:0] alu;
      {pcw, irw, mw, rw, adr, ill} = 6'b0;
      sa = 2'b00; sb = 2'b00; rs = 2'b00; alu = 3'b000;
      imm = (op == 7'b0100011) ? 2'b01 : (op == 7'b1100011) ? 2'b10 :
            (op == 7'b1101111) ? 2'b11 : 2'b00;
      case (st)
         0:  begin irw = 1'b1; pcw = 1'b1; sb = 2'b10; rs = 2'b10; end
         1:  begin sa = 2'b01; sb = 2'b01; end
         2:  begin sa = 2'b10; sb = 2'b01; end
         3:  adr = 1'b1;
         4:  begin rs = 2'b01; rw = 1'b1; end
         5:  begin adr = 1'b1; mw = 1'b1; end
         6:  begin sa = 2'b10; alu = exp_alu(f3, f7 && (op == 7'b0110011)); end
         7:  rw = 1'b1;
         8:  begin sa = 2'b10; sb = 2'b01; alu = exp_alu(f3, 1'b0); end
         9:  begin sa = 2'b01; sb = 2'b10; pcw = 1'b1; end
         10: begin
            sa = 2'b10; alu = 3'b001;
            pcw = (f3 == 3'd0) ? z : (f3 == 3'd1) ? !z : (f3 == 3'd4) ? s :
                  (f3 == 3'd5) ? !s : 1'b0;
         end
         11: ill = 1'b1;
         default: ;
      endcase
      return {pcw, irw, mw, rw, adr, sa, sb, rs, imm, alu, ill};
   endfunction

   task automatic test_reset();
      rst = 1'b0;
      opcode = 7'd0;
      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if ({state_dbg, pc_write, ir_write, mem_write, reg_write, illegal} !== 9'b0) begin
         n_fail++;
         $display("FAIL reset_hold: got state=%0d en=%b ill=%b expected state=0 en=0000 ill=0",
                  state_dbg, {pc_write, ir_write, mem_write, reg_write}, illegal);
      end
      rst = 1'b1;
      #1;
      n_checks++;
      if ({pc_write, ir_write} !== 2'b11) begin
         n_fail++;
         $display("FAIL reset_release_fetch: got pc/ir=%b expected 11", {pc_write, ir_write});
      end
   endtask

   task automatic test_lw_latency();
      int exp_st[8] = '{0, 1, 2, 3, 3, 3, 4, 0};
      opcode = 7'b0000011; funct3 = 3'b010;
      for (int k = 0; k < 8; k++) begin
         if (k > 0) begin @(negedge clk); #1; end
         n_checks++;
         if (state_dbg !== 4'(exp_st[k]) || reg_write !== (exp_st[k] == 4)) begin
            n_fail++;
            $display("FAIL lw_seq[%0d]: got state=%0d reg_write=%b expected state=%0d reg_write=%b",
                     k, state_dbg, reg_write, exp_st[k], exp_st[k] == 4);
         end
      end
   endtask

   task automatic test_rtype_sub();
      opcode = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1;
      @(negedge clk); #1;
      @(negedge clk); #1;
      n_checks++;
      if (state_dbg !== 4'd6 || alu_control !== 3'b001) begin
         n_fail++;
         $display("FAIL sub_execr: got state=%0d alu=%b expected state=6 alu=001",
                  state_dbg, alu_control);
      end
      @(negedge clk); #1;
      n_checks++;
      if (state_dbg !== 4'd7 || reg_write !== 1'b1) begin
         n_fail++;
         $display("FAIL sub_aluwb: got state=%0d reg_write=%b expected state=7 reg_write=1",
                  state_dbg, reg_write);
      end
      @(negedge clk); #1;
      n_checks++;
      if (state_dbg !== 4'd0) begin
         n_fail++;
         $display("FAIL sub_done: got state=%0d expected 0", state_dbg);
      end
      funct7b5 = 1'b0;
   endtask

   task automatic test_branch();
      for (int z = 1; z >= 0; z--) begin
         opcode = 7'b1100011; funct3 = 3'b000; zero = 1'(z);
         @(negedge clk); #1;
         @(negedge clk); #1;
         n_checks++;
         if (state_dbg !== 4'd10 || pc_write !== 1'(z)) begin
            n_fail++;
            $display("FAIL beq_zero%0d: got state=%0d pc_write=%b expected state=10 pc_write=%0d",
                     z, state_dbg, pc_write, z);
         end
         @(negedge clk); #1;
         n_checks++;
         if (state_dbg !== 4'd0) begin
            n_fail++;
            $display("FAIL beq_return%0d: got state=%0d expected 0", z, state_dbg);
         end
      end
   endtask

   task automatic test_trap();
      opcode = 7'b1110011; funct3 = 3'b000;
      @(negedge clk); #1;
      @(negedge clk); #1;
      for (int k = 0; k < 10; k++) begin
         n_checks++;
         if (state_dbg !== 4'd11 || illegal !== 1'b1 ||
             {pc_write, ir_write, mem_write, reg_write} !== 4'b0) begin
            n_fail++;
            $display("FAIL trap_hold[%0d]: got state=%0d ill=%b en=%b expected state=11 ill=1 en=0000",
                     k, state_dbg, illegal, {pc_write, ir_write, mem_write, reg_write});
         end
         @(negedge clk); #1;
      end
      rst = 1'b0;
      @(negedge clk); #1;
      n_checks++;
      if (state_dbg !== 4'd0 || illegal !== 1'b0) begin
         n_fail++;
         $display("FAIL trap_clear: got state=%0d ill=%b expected state=0 ill=0",
                  state_dbg, illegal);
      end
      rst = 1'b1;
   endtask

   task automatic test_branch_ext();
      opcode = 7'b1100011; funct3 = 3'b101; sign_flag = 1'b0; zero = 1'($urandom);
      @(negedge clk); #1;
      @(negedge clk); #1;
`ifdef MC_CTRL_BRANCH_EXT_EN
      n_checks++;
      if (state_dbg !== 4'd10 || pc_write !== 1'b1) begin
         n_fail++;
         $display("FAIL bge_taken: got state=%0d pc_write=%b expected state=10 pc_write=1",
                  state_dbg, pc_write);
      end
      @(negedge clk); #1;
`else
      n_checks++;
      if (state_dbg !== 4'd11 || illegal !== 1'b1) begin
         n_fail++;
         $display("FAIL bge_trap: got state=%0d ill=%b expected state=11 ill=1",
                  state_dbg, illegal);
      end
      rst = 1'b0;
      @(negedge clk); #1;
      rst = 1'b1;
`endif
   endtask

   task automatic test_reset_memwrite();
      opcode = 7'b0100011; funct3 = 3'b010;
      for (int k = 0; k < 3; k++) begin @(negedge clk); #1; end
      n_checks++;
      if (state_dbg !== 4'd5 || mem_write !== 1'b1) begin
         n_fail++;
         $display("FAIL sw_memwrite: got state=%0d mem_write=%b expected state=5 mem_write=1",
                  state_dbg, mem_write);
      end
      rst = 1'b0;
      #1;
      n_checks++;
      if (mem_write !== 1'b0) begin
         n_fail++;
         $display("FAIL sw_rst_gate: got mem_write=%b expected 0", mem_write);
      end
      @(negedge clk); #1;
      n_checks++;
      if (state_dbg !== 4'd0) begin
         n_fail++;
         $display("FAIL sw_rst_state: got state=%0d expected 0", state_dbg);
      end
      rst = 1'b1;
   endtask

   task automatic test_random();
      logic [6:0] ops[8] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                             7'b1101111, 7'b1100011, 7'b1110011, 7'b0000000};
      trace_t tr;
      logic [16:0] e;
      for (int n = 0; n < 60; n++) begin
         opcode = ops[$urandom_range(7)];
         if ($urandom_range(9) == 0) opcode = 7'($urandom);
         funct3 = 3'($urandom);
         funct7b5 = 1'($urandom);
         tr = trace(opcode, funct3);
         for (int k = 0; k < tr.size(); k++) begin
            if (k > 0) @(negedge clk);
            zero = 1'($urandom);
            sign_flag = 1'($urandom);
            #1;
            e = exp_out(tr[k], opcode, funct3, funct7b5, zero, sign_flag);
            n_checks++;
            if (state_dbg !== 4'(tr[k]) || obs !== e) begin
               n_fail++;
               $display("FAIL rand[%0d.%0d] op=%b f3=%b: got state=%0d out=%h expected state=%0d out=%h",
                        n, k, opcode, funct3, state_dbg, obs, tr[k], e);
            end
         end
         if (tr[tr.size()-1] == 11) begin
            rst = 1'b0;
            @(negedge clk); #1;
            rst = 1'b1;
         end else begin
            @(negedge clk);
         end
      end
   endtask

   initial begin
      test_reset();
      test_lw_latency();
      test_rtype_sub();
      test_branch();
      test_trap();
      test_branch_ext();
      test_reset_memwrite();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter MEM_LAT, default 1, meaning data-memory read wait cycles (legal range 1..4).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-low reset.
REQ-004 SHALL have port opcode, input, 7, instruction bits [6:0] from the instruction register.
REQ-005 SHALL have port funct3, input, 3, instruction bits [14:12].
REQ-006 SHALL have port funct7b5, input, 1, instruction bit 30.
REQ-007 SHALL have ports zero and sign_flag, input, 1 each, ALU flags.
REQ-008 SHALL have outputs pc_write, ir_write, mem_write, reg_write, adr_src, each 1 bit, datapath enables and address select.
REQ-009 SHALL have outputs alu_src_a, alu_src_b, result_src and imm_src, each 2 bits, and alu_control, 3 bits.
REQ-010 SHALL have outputs state_dbg, 4 bits, current state, and illegal, 1 bit, sticky trap flag.

Function
REQ-011 SHALL use states FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, ALUWB=7, EXECI=8, JAL=9, BRANCH=10, TRAP=11.
REQ-012 SHALL move FETCH->DECODE unconditionally; DECODE->MEMADR for 0000011/0100011, EXECR for 0110011, EXECI for 0010011, JAL for 1101111, BRANCH for 1100011, else TRAP.
REQ-013 SHALL move MEMADR->MEMREAD (lw) or MEMWRITE (sw); MEMREAD->MEMWB after MEM_LAT cycles counted by an internal counter; EXECR, EXECI, JAL->ALUWB; MEMWB, MEMWRITE, ALUWB, BRANCH->FETCH.
REQ-014 SHALL give cycle counts: lw 4+MEM_LAT; sw, R, I and jal 4; branch 3.
REQ-015 SHALL drive Moore outputs as follows, with unlisted outputs 0: FETCH ir_write=1, pc_write=1, src_a=00, src_b=10, result_src=10, alu add.
REQ-016 SHALL drive DECODE src_a=01, src_b=01, alu add; MEMADR src_a=10, src_b=01, alu add; MEMREAD adr_src=1; MEMWB result_src=01, reg_write=1.
REQ-017 SHALL drive MEMWRITE adr_src=1, mem_write=1; EXECR src_a=10, src_b=00; EXECI src_a=10, src_b=01; ALUWB reg_write=1.
REQ-018 SHALL drive JAL src_a=01, src_b=10, alu add, pc_write=1; BRANCH src_a=10, src_b=00, alu sub, pc_write=zero (Mealy term).
REQ-019 SHALL encode alu_control as add=000, sub=001, and=010, or=011, slt=101.
REQ-020 SHALL decode alu_control in EXECR/EXECI from funct3: 000 gives add, or sub when R-type and funct7b5=1; 010 gives slt; 110 gives or; 111 gives and.
REQ-021 SHALL send any other funct3 for R/I opcodes to TRAP from DECODE.
REQ-022 SHALL drive imm_src combinationally from opcode: I/lw 00, sw 01, branch 10, jal 11, others 00.
REQ-023 SHALL make TRAP absorbing: illegal=1, all enables 0, exit only by reset.
REQ-024 SHALL set the MEMREAD counter to 0 on entry and never let it exceed MEM_LAT-1.

Reset
REQ-025 SHALL, when rst=0 at a clock edge, set state=FETCH, counter=0 and illegal=0, aborting any instruction in progress.
REQ-026 SHALL force pc_write, ir_write, reg_write and mem_write to 0 while rst=0.

Configuration
REQ-027 SHALL, with MC_CTRL_BRANCH_EXT_EN defined, set BRANCH pc_write for funct3 000 to zero, 001 to !zero, 100 to sign_flag, 101 to !sign_flag, and send other funct3 to TRAP from DECODE.
REQ-028 SHALL, without MC_CTRL_BRANCH_EXT_EN, accept only branch funct3=000; any other branch funct3 goes to TRAP.

Structure
REQ-029 SHALL place the state encodings, opcode constants and alu_control codes in shared package rv_ctrl_pkg.
REQ-030 SHALL implement the funct3/funct7 to alu_control mapping as sub-module alu_decoder.

Verification
REQ-031 SHALL cover: rst=0 two cycles then release, opcode=0000011, MEM_LAT=3 -> states 0,1,2,3,3,3,4,0; reg_write=1 only in state 4.
REQ-032 SHALL cover: opcode=0110011, funct3=000, funct7b5=1 -> EXECR with alu_control=001, ALUWB reg_write=1, total 4 cycles.
REQ-033 SHALL cover: opcode=1100011, funct3=000, zero=1 then zero=0 -> pc_write=1 then 0 in BRANCH, back to FETCH.
REQ-034 SHALL cover: opcode=1110011 -> TRAP, illegal=1 held 10 cycles, all enables 0; rst=0 clears it.
REQ-035 SHALL cover: with macro defined, funct3=101, sign_flag=0 -> pc_write=1; without macro, same stimulus -> TRAP.
REQ-036 SHALL cover: rst=0 asserted during MEMWRITE -> mem_write=0 that cycle, next state FETCH.
